// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute boundary.
// Contents: RV32 opcode constants, the 11-bit control bundle struct (the
// field order matches the controller output), the NOP bundle, and
// rs1/rs2 usage helpers. This package has no ports.
package pipe_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jalr_sel;
    logic [1:0] rw_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // LUI, JAL and unknown opcodes read no source register.
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_STORE, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection.
// Ports:
//   opcode       decode opcode, used to qualify rs1/rs2 usage
//   rs1, rs2     decode source register indices
//   ex_mem_read  MemRead bit of the instruction currently in EX
//   ex_valid     EX holds a real instruction
//   ex_rd        destination register of the instruction in EX
//   load_use     decode needs data that the load in EX has not produced yet
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  ex_mem_read,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = uses_rs1(opcode) && (ex_rd == rs1);
  assign rs2_hit = uses_rs2(opcode) && (ex_rd == rs2);

  // x0 is hardwired to zero, so a load into x0 never produces a hazard.
  assign load_use = ex_mem_read && ex_valid && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// On a load-use hazard, stall_o holds PC and IF/ID and a bubble enters EX.
// flush_i (a branch/jump taken in EX) squashes the decode slot and takes
// priority over a stall.
// Optional build macro ID_EX_PERF_CNT_EN adds the counters bubble_cnt_o
// and flush_cnt_o.
// Ports:
//   clk, reset            rising-edge clock; synchronous active-high reset
//   id_*                  decode-stage inputs: opcode, control, pc, operands,
//                         immediate, indices, funct3, funct7
//   flush_i               squash the decode slot
//   ex_*                  registered values presented to execute
//   ex_valid_o            EX holds a real instruction
//   stall_o               combinational: hold PC and IF/ID this cycle
//   bubble_cnt_o          (optional) count of stall cycles
//   flush_cnt_o           (optional) count of flush cycles
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_opcode_i,
  input  logic [10:0]           id_ctrl_i,
  input  logic [PC_W-1:0]       id_pc_i,
  input  logic [DATA_W-1:0]     id_rd1_i,
  input  logic [DATA_W-1:0]     id_rd2_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [2:0]            id_funct3_i,
  input  logic [6:0]            id_funct7_i,
  input  logic                  flush_i,
  output logic [10:0]           ex_ctrl_o,
  output logic [PC_W-1:0]       ex_pc_o,
  output logic [DATA_W-1:0]     ex_rd1_o,
  output logic [DATA_W-1:0]     ex_rd2_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [2:0]            ex_funct3_o,
  output logic [6:0]            ex_funct7_o,
  output logic                  ex_valid_o,
  output logic                  stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           bubble_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  ctrl_t ex_ctrl;
  logic  load_use;

  assign ex_ctrl_o = ex_ctrl;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .opcode      (id_opcode_i),
    .rs1         (id_rs1_i),
    .rs2         (id_rs2_i),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_valid    (ex_valid_o),
    .ex_rd       (ex_rd_o),
    .load_use    (load_use)
  );

  // A flush wins over the hazard: the wrong-path decode is dropped, so the
  // front end must not be held. Reset masks stall_o before the EX registers
  // hold defined values.
  assign stall_o = load_use && !flush_i && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl     <= CTRL_NOP;
      ex_valid_o  <= 1'b0;
      ex_pc_o     <= '0;
      ex_rd1_o    <= '0;
      ex_rd2_o    <= '0;
      ex_imm_o    <= '0;
      ex_rs1_o    <= '0;
      ex_rs2_o    <= '0;
      ex_rd_o     <= '0;
      ex_funct3_o <= '0;
      ex_funct7_o <= '0;
    end else begin
      // The datapath loads every cycle. Its value only matters when
      // ex_valid_o is set, because the zeroed control bundle keeps a bubble
      // inert.
      ex_pc_o     <= id_pc_i;
      ex_rd1_o    <= id_rd1_i;
      ex_rd2_o    <= id_rd2_i;
      ex_imm_o    <= id_imm_i;
      ex_rs1_o    <= id_rs1_i;
      ex_rs2_o    <= id_rs2_i;
      ex_rd_o     <= id_rd_i;
      ex_funct3_o <= id_funct3_i;
      ex_funct7_o <= id_funct7_i;
      if (flush_i || stall_o) begin
        // The bubble clears MemRead, so a stall cannot repeat on the
        // instruction that re-presents next cycle.
        ex_ctrl    <= CTRL_NOP;
        ex_valid_o <= 1'b0;
      end else begin
        ex_ctrl    <= ctrl_t'(id_ctrl_i);
        ex_valid_o <= 1'b1;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (stall_o) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      if (flush_i) flush_cnt_o  <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam logic [10:0] C_ADDI = 11'b1_0_1_0_0_10_0_0_00;
  localparam logic [10:0] C_LW   = 11'b1_1_1_1_0_00_0_0_00;
  localparam logic [10:0] C_ADD  = 11'b0_0_1_0_0_10_0_0_00;
  localparam logic [10:0] C_LUI  = 11'b1_0_1_0_0_00_0_0_11;
  localparam logic [10:0] C_SW   = 11'b1_0_0_0_1_00_0_0_00;
  localparam logic [6:0]  R  = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0]  ST = 7'b0100011, LU = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  id_opcode;
  logic [10:0] id_ctrl;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        flush;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_valid, stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .id_opcode_i(id_opcode), .id_ctrl_i(id_ctrl),
    .id_pc_i(id_pc), .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_funct3_i(id_funct3), .id_funct7_i(id_funct7), .flush_i(flush),
    .ex_ctrl_o(ex_ctrl), .ex_pc_o(ex_pc), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2),
    .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_funct3_o(ex_funct3), .ex_funct7_o(ex_funct7), .ex_valid_o(ex_valid),
    .stall_o(stall)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic [10:0] ctrl;
    logic        valid;
    logic        chk_dp;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, rd1, rd2, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One decode cycle: drive at negedge, check stall_o, push the expected EX
  // contents, then pop and compare after the capturing edge.
  task automatic step(input string tag, input logic [6:0] opc, input logic [10:0] ctrl,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic fl, input logic rst, input logic exp_stall);
    exp_t e;
    @(negedge clk);
    reset = rst; flush = fl;
    id_opcode = opc; id_ctrl = ctrl; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_pc = id_pc + 32'd4; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
    #1;
    chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    e.tag = tag;
    if (rst) begin
      e.ctrl = '0; e.valid = 1'b0; e.chk_dp = 1'b1;
      e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.pc = '0; e.rd1 = '0; e.rd2 = '0;
      e.imm = '0; e.f3 = '0; e.f7 = '0;
    end else begin
      e.valid  = !(fl || exp_stall);
      e.ctrl   = e.valid ? ctrl : 11'd0;
      e.chk_dp = e.valid;
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.pc = id_pc; e.rd1 = id_rd1;
      e.rd2 = id_rd2; e.imm = id_imm; e.f3 = id_funct3; e.f7 = id_funct7;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) chk({tag, ".queue"}, 64'd0, 64'd1);
    else begin
      e = q.pop_front();
      chk({e.tag, ".ctrl"},  64'(ex_ctrl),  64'(e.ctrl));
      chk({e.tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
      if (e.chk_dp) begin
        chk({e.tag, ".rd"},  64'(ex_rd),  64'(e.rd));
        chk({e.tag, ".rs1"}, 64'(ex_rs1), 64'(e.rs1));
        chk({e.tag, ".rs2"}, 64'(ex_rs2), 64'(e.rs2));
        chk({e.tag, ".pc"},  64'(ex_pc),  64'(e.pc));
        chk({e.tag, ".rd1"}, 64'(ex_rd1), 64'(e.rd1));
        chk({e.tag, ".rd2"}, 64'(ex_rd2), 64'(e.rd2));
        chk({e.tag, ".imm"}, 64'(ex_imm), 64'(e.imm));
        chk({e.tag, ".f3"},  64'(ex_funct3), 64'(e.f3));
        chk({e.tag, ".f7"},  64'(ex_funct7), 64'(e.f7));
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; id_pc = 32'h100;
    id_opcode = '0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_funct3 = '0; id_funct7 = '0;

    // reset held two cycles with a live-looking hazard on the inputs
    step("rst0", R, C_LW, 5'd6, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0);
    step("rst1", R, C_LW, 5'd6, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0);

    step("addi_x5", I, C_ADDI, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("addi.rd1_value", 64'(ex_rd1 === ex_rd1), 64'd1);

    step("lw_x6_a",   LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("add_stall", R,  C_ADD, 5'd6, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1);
    step("add_retry", R,  C_ADD, 5'd6, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);

    step("lw_x6_b", LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("lui_x6",  LU, C_LUI, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0);

    step("lw_x0",   LD, C_LW,  5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("add_x0",  R,  C_ADD, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);

    step("lw_x6_c",  LD, C_LW,   5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("addi_rs2", I,  C_ADDI, 5'd9, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0);

    step("lw_x6_d",   LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("add_flush", R,  C_ADD, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);

    // rs2-side hazards: R-type and store
    step("lw_x6_e",    LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("add_rs2",    R,  C_ADD, 5'd1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1);
    step("add_rs2_re", R,  C_ADD, 5'd1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0);
    step("lw_x6_f",    LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("sw_rs2",     ST, C_SW,  5'd3, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sw_rs2_re",  ST, C_SW,  5'd3, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    step("flush_plain", I, C_ADDI, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);

`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk);
    chk("bubble_cnt", 64'(bubble_cnt), 64'd3);
    chk("flush_cnt",  64'(flush_cnt),  64'd2);
`endif

    // reset arriving while a hazard is pending
    step("lw_x6_g",  LD, C_LW,  5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    step("rst_mid",  R,  C_ADD, 5'd6, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0);
    step("post_rst", R,  C_ADD, 5'd6, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);

`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk);
    chk("bubble_cnt_rst", 64'(bubble_cnt), 64'd0);
    chk("flush_cnt_rst",  64'(flush_cnt),  64'd0);
`endif

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
